// File: rtl/serial_rx_param.sv
// Parametrised serial frame receiver: start bit, DATA_W data bits, optional parity, 1-2 stop bits.
// Good frames, parity errors and framing errors are reported on separate one-cycle strobes.
module serial_rx_param #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 1,
    parameter int STOP_BITS  = 1,
    parameter int LSB_FIRST  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [5:0] LAST_DATA  = 6'(DATA_W - 1);
    localparam logic [5:0] LAST_STOP  = 6'(STOP_BITS - 1);
    localparam logic       HAS_PARITY = (PARITY_EN != 0);
    localparam logic       ODD_SENSE  = (PARITY_ODD != 0);

    logic [2:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_ins;
    logic              par_q, par_d;
    logic              bad_par_q, bad_par_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              busy_q, busy_d;

    // Each data bit lands directly in its final position, so bit order is a pure index mapping.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ins
        localparam logic [5:0] POS = (LSB_FIRST != 0) ? 6'(gi) : 6'(DATA_W - 1 - gi);
        assign shift_ins[gi] = (cnt_q == POS) ? in : shift_q[gi];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bad_par_d  = bad_par_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!in) begin
                    state_d   = S_DATA;
                    cnt_d     = '0;
                    par_d     = 1'b0;
                    bad_par_d = 1'b0;
                end
            end
            S_DATA: begin
                shift_d = shift_ins;
                par_d   = par_q ^ in;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == LAST_DATA) begin
                    cnt_d   = '0;
                    state_d = HAS_PARITY ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                bad_par_d = ((par_q ^ in) != ODD_SENSE);
                state_d   = S_STOP;
            end
            S_STOP: begin
                if (!in) begin
                    state_d = S_ERROR;
                    ferr_d  = 1'b1;
                end else if (cnt_q == LAST_STOP) begin
                    state_d = S_DONE;
                    if (bad_par_q) begin
                        perr_d = 1'b1;
                    end else begin
                        done_d     = 1'b1;
                        out_data_d = shift_q;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DONE: begin
                // A 0 right after the last stop bit starts the next frame with no idle gap.
                if (!in) begin
                    state_d   = S_DATA;
                    cnt_d     = '0;
                    par_d     = 1'b0;
                    bad_par_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                if (in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_DATA) || (state_d == S_PARITY) || (state_d == S_STOP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bad_par_q  <= 1'b0;
            out_data_q <= '0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bad_par_q  <= bad_par_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    assign out_data   = out_data_q;
    assign done       = done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: doc/serial_rx_param.md
Name: serial_rx_param

Overview:
- Parametrised synchronous serial frame receiver. It is the successor to the team's fixed 8-bit odd-parity receiver.
- Samples one line bit per clk. Accepts a start bit, DATA_W data bits, an optional parity bit of either sense, and 1 or 2 stop bits.
- Reports good frames, parity errors and framing errors on separate one-cycle strobes.
- Sits behind the line input and feeds byte/word consumers in the serial datapath.

Parameters:
- DATA_W, 8: number of data bits per frame (1..32).
- PARITY_EN, 1: 1 = a parity bit follows the data; 0 = no parity bit.
- PARITY_ODD, 1: 1 = odd parity (data bits plus parity bit contain an odd number of ones); 0 = even parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits (1 or 2).
- LSB_FIRST, 1: 1 = first data bit is out_data[0]; 0 = first data bit is out_data[DATA_W-1].

Ports:
- clk  input  1  rising-edge clock; one line bit per cycle.
- reset  input  1  synchronous, active-low reset (0 = reset).
- in  input  1  serial line; idles at 1.
- out_data  output  DATA_W  last good frame's data, held until the next good frame.
- done  output  1  one-cycle strobe: good frame received, out_data updated in the same cycle.
- parity_err  output  1  one-cycle strobe: frame complete with correct stop bits but wrong parity.
- frame_err  output  1  one-cycle strobe: a stop bit was sampled as 0.
- busy  output  1  1 while in DATA, PARITY or STOP.

Behaviour:
- All outputs and state are registered. Every transition uses the in value sampled at the rising clk edge.
- Reset (reset=0 at an edge), from any state including mid-frame:
  - state=IDLE, out_data=0, done=0, parity_err=0, frame_err=0, busy=0.
  - Bit counter and shift register cleared.
- States: IDLE, DATA, PARITY, STOP, DONE, ERROR.
- IDLE: in=0 is the start bit -> DATA with bit counter 0. in=1 -> stay in IDLE.
- DATA:
  - Shift in one bit per cycle and increment the counter.
  - After DATA_W bits: PARITY_EN=1 -> PARITY; otherwise -> STOP.
  - A running parity accumulator XORs every data bit and is cleared when the start bit is accepted.
- PARITY: sample the parity bit. Set an internal bad-parity flag if (XOR of data bits ^ parity bit) != PARITY_ODD. Go to STOP.
- STOP:
  - Sample STOP_BITS stop bits, one per cycle.
  - Any stop bit = 0 -> ERROR immediately, with frame_err=1 for the following cycle. Remaining stop bits are not checked.
  - All stop bits = 1 -> DONE.
- DONE (lasts exactly one cycle):
  - Parity good or PARITY_EN=0: done=1 and out_data loads the shift register.
  - Bad parity: parity_err=1 and out_data unchanged.
  - Sampled in=0 is a new start bit -> DATA (back-to-back frames, no idle gap). in=1 -> IDLE.
- ERROR: stay while in=0. in=1 -> IDLE. A 0 seen in ERROR is never treated as a start bit.
- Latency: with the start bit sampled at edge t, data bit i is sampled at t+1+i and the parity bit at t+1+DATA_W.
  - Stop bits are sampled at t+1+DATA_W+P+k, where P=PARITY_EN and k=0..STOP_BITS-1.
  - done, parity_err and frame_err are high during the cycle after the edge that sampled the deciding bit.
- done, parity_err and frame_err are mutually exclusive and never high for two consecutive cycles from the same frame.
- busy=0 in IDLE, DONE and ERROR.
- out_data changes only on reset or in the cycle done=1. It is never X.

Test Plan:
- Default params. Stimulus: idle 1s, then 0, 1,0,1,0,0,1,0,1 (0xA5 LSB first), parity 1, stop 1, then idle 1s. Response: done=1 for one cycle, 11 cycles after the start-bit edge; out_data=0xA5; no error strobes; out_data still 0xA5 ten idle cycles later.
- Default params, 0xA5 frame with parity bit 0. Response: parity_err=1 for one cycle, done stays 0, out_data keeps its previous value (0xA5 or 0 after reset).
- Default params, frame 0x3C with stop bit 0, then in=0 for 3 cycles, then in=1, then a valid 0x3C frame. Response: frame_err pulses once; no frame starts during the 0s; the second frame gives done=1 with out_data=0x3C.
- Default params, back-to-back frames 0x12 then 0x34, where the second start bit immediately follows the first stop bit. Response: done pulses twice, 11 cycles apart; out_data=0x12 then 0x34.
- DATA_W=7, PARITY_EN=0, STOP_BITS=2, LSB_FIRST=0. Frame: 0, bits 1,0,1,0,1,0,1, stops 1,1. Response: done=1 with out_data=7'h55. Repeating the frame with the second stop bit 0 gives frame_err and no done.
- Default params. Assert reset=0 for one cycle after data bit 4, then send a valid 0x81 frame. Response: all outputs return to 0 immediately after the reset edge; the subsequent 0x81 frame produces done=1 with out_data=0x81.
